// File: rtl/udp_tx_scheduler.sv
// Two-requester round-robin scheduler in front of the UDP/IP transmit engine.
// Optional WAIT watchdog enabled by defining UDP_SCHED_TIMEOUT_EN.
module udp_tx_scheduler #(
  parameter int IFG_CYCLES     = 1024,
  parameter int MAX_PAYLOAD    = 1472,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sched_en,
  input  logic [1:0]  req,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  input  logic        tx_done,
  output logic [1:0]  grant,
  output logic        ch_sel,
  output logic        tx_start,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        busy,
  output logic        err_len,
  output logic        tx_abort,
  output logic [15:0] frames_sent
);

  // One counter serves both the inter-frame gap and the watchdog, so size it for the larger.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] IFG_END = CNT_W'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_START, S_WAIT, S_GAP} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [1:0]        grant_q, grant_d;
  logic              ch_sel_q, ch_sel_d;
  logic [15:0]       data_len_q, data_len_d;
  logic [15:0]       total_len_q, total_len_d;
  logic              len_bad_q, len_bad_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       frames_q, frames_d;
  logic              tx_start_q, tx_start_d;
  logic              err_len_q, err_len_d;
`ifdef UDP_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_END = CNT_W'(TIMEOUT_CYCLES - 1);
  logic              tx_abort_q, tx_abort_d;
`endif

  // prio_q = 1 means ch1 wins a tie.
  logic        win_ch;
  logic [15:0] win_len;
  logic        win_bad;
  assign win_ch  = req[1] & (~req[0] | prio_q);
  assign win_len = win_ch ? len1 : len0;
  assign win_bad = (win_len == 16'd0) || ({16'd0, win_len} > 32'(MAX_PAYLOAD));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    prio_d      = prio_q;
    grant_d     = grant_q;
    ch_sel_d    = ch_sel_q;
    data_len_d  = data_len_q;
    total_len_d = total_len_q;
    len_bad_d   = len_bad_q;
    cnt_d       = cnt_q;
    frames_d    = frames_q;
    tx_start_d  = 1'b0;
    err_len_d   = 1'b0;
`ifdef UDP_SCHED_TIMEOUT_EN
    tx_abort_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (sched_en && (req != 2'b00)) state_d = S_ARB;
      S_ARB: begin
        if (req == 2'b00) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_LOAD;
          grant_d   = win_ch ? 2'b10 : 2'b01;
          ch_sel_d  = win_ch;
          prio_d    = ~win_ch;
          len_bad_d = win_bad;
          if (!win_bad) begin
            data_len_d  = win_len + 16'd8;
            total_len_d = win_len + 16'd28;
          end
        end
      end
      S_LOAD: begin
        if (len_bad_q) begin
          err_len_d = 1'b1;
          grant_d   = 2'b00;
          cnt_d     = '0;
          state_d   = S_GAP;
        end else begin
          tx_start_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          frames_d = frames_q + 16'd1;
          grant_d  = 2'b00;
          cnt_d    = '0;
          state_d  = S_GAP;
        end
`ifdef UDP_SCHED_TIMEOUT_EN
        else if (cnt_q == TMO_END) begin
          tx_abort_d = 1'b1;
          grant_d    = 2'b00;
          cnt_d      = '0;
          state_d    = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_GAP: begin
        if (cnt_q == IFG_END) state_d = S_IDLE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      prio_q      <= 1'b0;
      grant_q     <= 2'b00;
      ch_sel_q    <= 1'b0;
      data_len_q  <= 16'd0;
      total_len_q <= 16'd0;
      len_bad_q   <= 1'b0;
      cnt_q       <= '0;
      frames_q    <= 16'd0;
      tx_start_q  <= 1'b0;
      err_len_q   <= 1'b0;
`ifdef UDP_SCHED_TIMEOUT_EN
      tx_abort_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q     <= state_d;
      prio_q      <= prio_d;
      grant_q     <= grant_d;
      ch_sel_q    <= ch_sel_d;
      data_len_q  <= data_len_d;
      total_len_q <= total_len_d;
      len_bad_q   <= len_bad_d;
      cnt_q       <= cnt_d;
      frames_q    <= frames_d;
      tx_start_q  <= tx_start_d;
      err_len_q   <= err_len_d;
`ifdef UDP_SCHED_TIMEOUT_EN
      tx_abort_q  <= tx_abort_d;
`endif
    end
  end

  assign grant           = grant_q;
  assign ch_sel          = ch_sel_q;
  assign tx_start        = tx_start_q;
  assign tx_data_length  = data_len_q;
  assign tx_total_length = total_len_q;
  assign busy            = (state_q != S_IDLE);
  assign err_len         = err_len_q;
  assign frames_sent     = frames_q;
`ifdef UDP_SCHED_TIMEOUT_EN
  assign tx_abort = tx_abort_q;
`else
  assign tx_abort = 1'b0;
`endif

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Two-requester scheduler in front of the UDP/IP transmit engine. It arbitrates frame requests from the FFT-spectrum and FIR-audio sources, loads the length fields for the winner, and pulses the engine's start. It then waits for end-of-frame, enforces an inter-frame gap, and optionally aborts a hung frame. It sits between the two source buffers and the transmit engine, in the engine's clock domain.

## Interface
- `IFG_CYCLES`, default 1024: idle cycles after each frame before the next grant (minimum 1).
- `MAX_PAYLOAD`, default 1472: largest legal UDP payload in bytes.
- `TIMEOUT_CYCLES`, default 65536: watchdog limit in WAIT (used only with the macro).

- `clk` in 1: engine clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sched_en` in 1: 1 = grants allowed; 0 = finish the current frame, then hold in IDLE.
- `req` in 2: level request per channel; held until granted.
- `len0`, `len1` in 16: payload bytes for ch0/ch1; sampled in LOAD.
- `tx_done` in 1: one-cycle end-of-frame pulse from the engine.
- `grant` out 2: one-hot; held from LOAD through WAIT.
- `ch_sel` out 1: index of the granted channel; selects the data mux.
- `tx_start` out 1: one-cycle start pulse to the engine.
- `tx_data_length` out 16: UDP length = payload + 8.
- `tx_total_length` out 16: IP total length = payload + 28.
- `busy` out 1: high in every state except IDLE.
- `err_len` out 1: one-cycle pulse when a request is rejected for its length.
- `tx_abort` out 1: one-cycle pulse on watchdog expiry.
- `frames_sent` out 16: count of completed frames; wraps at 0xFFFF → 0.

## Operation
- **States:** IDLE, ARB, LOAD, START, WAIT, GAP.
- **IDLE → ARB:** when `sched_en` = 1 and `req` ≠ 0.
- **ARB:**
  - Round-robin pick. The channel not granted last wins a tie.
  - After reset, ch0 has priority.
  - Go to LOAD. If `req` dropped to 0 in the meantime, return to IDLE.
- **LOAD:**
  - Register `grant`, `ch_sel`, and the winner's length.
  - Length of 0 or > `MAX_PAYLOAD`:
    - pulse `err_len` and clear `grant`;
    - the priority pointer still advances;
    - go to GAP.
  - Otherwise:
    - `tx_data_length` ← len + 8 and `tx_total_length` ← len + 28 (16-bit; no overflow for legal lengths);
    - go to START.
- **START:** `tx_start` = 1 for exactly this cycle, then WAIT.
- **WAIT:**
  - Hold `grant`, `ch_sel` and both lengths stable.
  - On `tx_done`: `frames_sent` += 1, clear `grant`, go to GAP.
- **GAP:**
  - Count `IFG_CYCLES`, then go to IDLE.
  - `req` and `sched_en` are ignored while counting.
- **Other rules:**
  - `tx_done` outside WAIT is ignored.
  - A `req` change during LOAD/START/WAIT does not affect the current frame.
  - `sched_en` falling mid-frame does not abort; the frame completes normally.
- **Reset (any time, including mid-frame):**
  - state = IDLE; all outputs 0 (`grant` = 2'b00, `ch_sel` = 0, both lengths 0, `frames_sent` = 0);
  - priority pointer → ch0; gap and watchdog counters cleared.

## Timing
- Request to `tx_start`: `req` sampled high in IDLE at edge n gives ARB at n+1, LOAD at n+2, START at n+3. `tx_start` is high in the cycle after edge n+3.
- `grant`, `ch_sel` and lengths are valid 1 cycle before `tx_start` and remain stable until the cycle after `tx_done`.
- `tx_done` at edge m:
  - GAP begins at m+1;
  - IDLE is reached at m+1+`IFG_CYCLES`;
  - the earliest next `tx_start` is 3 cycles after IDLE.
- `err_len`, `tx_abort` and `tx_start` are each exactly one cycle wide and registered.

## Configuration
- **`UDP_SCHED_TIMEOUT_EN` defined:**
  - A watchdog counts cycles in WAIT.
  - When it reaches `TIMEOUT_CYCLES` without `tx_done`: pulse `tx_abort`, clear `grant`, go to GAP.
  - `frames_sent` is not incremented.
- **Not defined:**
  - No watchdog logic; `tx_abort` is tied to 0.
  - WAIT is left only on `tx_done` or reset.

## Test plan
- Reset release, `req` = 2'b01, `len0` = 1024, `tx_done` 500 cycles after `tx_start`:
  - `grant` = 01, `tx_data_length` = 1032, `tx_total_length` = 1052;
  - `tx_start` 3 cycles after the request;
  - `frames_sent` = 1; next grant no earlier than `IFG_CYCLES` + 3 cycles after `tx_done`.
- `req` = 2'b11 held, 4 frames → grant order 01, 10, 01, 10; `frames_sent` = 4.
- `len1` = 0, then `len1` = 1473 →
  - `err_len` pulses each time, no `tx_start`, `frames_sent` unchanged;
  - ch0 is served next if requesting.
- `sched_en` dropped during WAIT → frame completes on `tx_done`, `frames_sent` increments, then the block stays in IDLE with `busy` = 0.
- `rst_n` asserted mid-WAIT → all outputs 0 immediately (asynchronous); after release with `req` = 2'b11, ch0 is granted first.
- With `UDP_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 100, no `tx_done` →
  - `tx_abort` pulses 100 cycles into WAIT, `grant` cleared, `frames_sent` unchanged;
  - a late `tx_done` is ignored.
